// File: rtl/sram_pkg.sv
// Shared types for the generic two-port SRAM model.
// Holds the init FSM encoding and collision policy codes.
package sram_pkg;

  typedef enum logic {
    SRAM_CLEAR,
    SRAM_READY
  } sram_state_e;

  localparam int COLLISION_READ_OLD      = 0;
  localparam int COLLISION_WRITE_THROUGH = 1;

endpackage

// File: rtl/sram_init_clear.sv
// Post-reset zero-initialisation sequencer.
// Walks every row once, then parks in READY until reset.
module sram_init_clear
  import sram_pkg::*;
#(
  parameter int NUM_ROWS  = 4096,
  parameter int ZERO_INIT = 1,
  parameter int AW        = 12
) (
  input  logic          CLK,
  input  logic          RSTB,
  output logic          clear_we,
  output logic [AW-1:0] clear_addr,
  output logic          init_done
);

  localparam logic [AW-1:0] LAST = AW'(NUM_ROWS - 1);

  sram_state_e   state;
  logic [AW-1:0] cnt;

  always_ff @(posedge CLK or negedge RSTB) begin
    if (!RSTB) begin
      state     <= (ZERO_INIT != 0) ? SRAM_CLEAR : SRAM_READY;
      cnt       <= '0;
      init_done <= (ZERO_INIT == 0);
    end else begin
      case (state)
        SRAM_CLEAR: begin
          if (cnt == LAST) begin
            state     <= SRAM_READY;
            init_done <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        SRAM_READY: begin
          state <= SRAM_READY;
        end
        default: begin
          state <= SRAM_READY;
        end
      endcase
    end
  end

  assign clear_we   = (state == SRAM_CLEAR);
  assign clear_addr = cnt;

endmodule

// File: rtl/generic_two_port_tsmc_sram.sv
// 1R1W behavioural SRAM with bit-masked writes, collision policy,
// 1- or 2-cycle read latency and optional post-reset clear.
module generic_two_port_tsmc_sram
  import sram_pkg::*;
#(
  parameter int WIDTH          = 128,
  parameter int NUM_ROWS       = 4096,
  parameter int READ_LATENCY   = 1,
  parameter int COLLISION_MODE = 0,
  parameter int ZERO_INIT      = 1,
  localparam int AddressWidth  = $clog2(NUM_ROWS)
) (
  input  logic                    CLK,
  input  logic                    RSTB,
  input  logic                    RE,
  input  logic [AddressWidth-1:0] AA,
  input  logic                    WE,
  input  logic [AddressWidth-1:0] AB,
  input  logic [WIDTH-1:0]        D,
  input  logic [WIDTH-1:0]        M,
  output logic [WIDTH-1:0]        Q,
  output logic                    QV,
  output logic                    INIT_DONE
);

  localparam int AW = AddressWidth;
  localparam logic [AW:0] ROWS = (AW + 1)'(NUM_ROWS);

  if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_lat
    $fatal(1, "READ_LATENCY must be 1 or 2");
  end
  if (COLLISION_MODE != COLLISION_READ_OLD &&
      COLLISION_MODE != COLLISION_WRITE_THROUGH) begin : g_bad_col
    $fatal(1, "COLLISION_MODE must be 0 or 1");
  end
  if (NUM_ROWS < 2) begin : g_bad_rows
    $fatal(1, "NUM_ROWS must be at least 2");
  end

  logic [WIDTH-1:0] mem [NUM_ROWS];

  logic          clear_we;
  logic [AW-1:0] clear_addr;
  logic          init_done;

  sram_init_clear #(
    .NUM_ROWS  (NUM_ROWS),
    .ZERO_INIT (ZERO_INIT),
    .AW        (AW)
  ) u_init (
    .CLK        (CLK),
    .RSTB       (RSTB),
    .clear_we   (clear_we),
    .clear_addr (clear_addr),
    .init_done  (init_done)
  );

  assign INIT_DONE = init_done;

  logic             wr_in, rd_in;
  logic             wr_ok, rd_ok;
  logic             hit;
  logic [WIDTH-1:0] wr_merged;
  logic [WIDTH-1:0] rd_data;

  assign wr_in = ({1'b0, AB} < ROWS);
  assign rd_in = ({1'b0, AA} < ROWS);
  assign wr_ok = init_done & WE & wr_in;
  assign rd_ok = init_done & RE;
  assign hit   = wr_ok & (AA == AB);

  always_comb begin
    wr_merged = '0;
    if (wr_in) begin
      wr_merged = (D & M) | (mem[AB] & ~M);
    end
  end

  // Write-through only changes what this read sees; the array is
  // written identically in both collision modes.
  always_comb begin
    rd_data = '0;
    if (rd_in) begin
      if (COLLISION_MODE == COLLISION_WRITE_THROUGH && hit) begin
        rd_data = wr_merged;
      end else begin
        rd_data = mem[AA];
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (clear_we) begin
      mem[clear_addr] <= '0;
    end else if (wr_ok) begin
      mem[AB] <= wr_merged;
    end
  end

  logic [WIDTH-1:0] p_d;
  logic             p_v;

  if (READ_LATENCY == 2) begin : g_lat2
    always_ff @(posedge CLK or negedge RSTB) begin
      if (!RSTB) begin
        p_d <= '0;
        p_v <= 1'b0;
      end else begin
        p_v <= rd_ok;
        if (rd_ok) begin
          p_d <= rd_data;
        end
      end
    end
  end else begin : g_lat1
    assign p_d = rd_data;
    assign p_v = rd_ok;
  end

  always_ff @(posedge CLK or negedge RSTB) begin
    if (!RSTB) begin
      Q  <= '0;
      QV <= 1'b0;
    end else begin
      QV <= p_v;
      if (p_v) begin
        Q <= p_d;
      end
    end
  end

endmodule

// File: doc/generic_two_port_tsmc_sram.md
Name: generic_two_port_tsmc_sram

Overview:
- Parametrised successor to the team's single-port behavioural SRAM model.
- One read port and one write port (1R1W) share a clock.
- Adds per-bit masked writes, a selectable read-collision policy, a configurable read latency with a read-valid strobe, and an optional post-reset zero-initialisation sequencer.
- Used as the synthesis/simulation stand-in for TSMC two-port macros in neuron-state and weight buffers.

Parameters:
- WIDTH, 128, data word width in bits.
- NUM_ROWS, 4096, number of words; need not be a power of two.
- READ_LATENCY, 1, read latency in clock edges; legal values are 1 and 2 only.
- COLLISION_MODE, 0, behaviour on a same-address read and write in the same cycle: 0 = read returns old data, 1 = write-through (read returns merged new data).
- ZERO_INIT, 1, when 1 an init FSM clears all rows after reset.
- AddressWidth (localparam), $clog2(NUM_ROWS), address bus width.

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- RSTB  input  1  asynchronous active-low reset.
- RE  input  1  read enable, active high.
- AA  input  AddressWidth  read address.
- WE  input  1  write enable, active high.
- AB  input  AddressWidth  write address.
- D  input  WIDTH  write data.
- M  input  WIDTH  write bit mask; 1 = overwrite that bit.
- Q  output  WIDTH  read data; holds its last value between reads.
- QV  output  1  one-cycle pulse marking new read data on Q.
- INIT_DONE  output  1  high once memory is usable.

Behaviour:
- Reset (RSTB low, asynchronous):
  - Q=0, QV=0, all read pipeline registers 0.
  - INIT_DONE=0 if ZERO_INIT=1, else 1.
  - Init counter=0; FSM enters CLEAR if ZERO_INIT=1, else READY.
  - Array contents are not reset.
- FSM states: CLEAR, READY.
  - CLEAR: each rising edge writes row[cnt] <= 0, then cnt++.
    - On the edge that writes row NUM_ROWS-1, move to READY and set INIT_DONE=1. INIT_DONE is therefore visible after exactly NUM_ROWS edges.
    - RE and WE are ignored; QV stays 0.
  - READY: terminal state. Only reset leaves it.
  - Reset asserted mid-CLEAR aborts the sequence. Clearing restarts from row 0 after release.
- Write (READY, WE=1, AB<NUM_ROWS): row[AB] <= (D & M) | (row[AB] & ~M).
  - M=0 leaves the row unchanged.
  - AB>=NUM_ROWS: write is dropped silently.
- Read (READY, RE=1) sampled at edge N:
  - READ_LATENCY=1: Q and QV update at edge N.
  - READ_LATENCY=2: Q and QV update at edge N+1 via an internal data+valid stage.
  - QV is high for exactly one cycle per accepted read. Back-to-back reads give continuous QV with full throughput.
  - AA>=NUM_ROWS: returns all-zero data, QV still pulses.
  - RE=0: Q holds its value and QV=0.
- Collision (RE=1, WE=1, AA==AB, in range):
  - COLLISION_MODE=0: Q gets the pre-write row.
  - COLLISION_MODE=1: Q gets (D & M) | (old & ~M).
  - The array is updated in both modes.
- Parameter checks at elaboration: fatal if READ_LATENCY is not in {1,2}, COLLISION_MODE is not in {0,1}, or NUM_ROWS<2.

Decomposition:
- Shared package sram_pkg holds:
  - typedef enum logic {SRAM_CLEAR, SRAM_READY} sram_state_e
  - localparam COLLISION_READ_OLD=0, COLLISION_WRITE_THROUGH=1
- One sub-module, sram_init_clear: owns the FSM and row counter, and outputs clear_we, clear_addr and init_done.
- The top level owns the array, write merge, collision mux and read pipeline.

Test Plan (WIDTH=8, NUM_ROWS=12, defaults unless stated):
- Init: release RSTB; check INIT_DONE=0 for 11 edges and 1 after edge 12. Then read rows 0..11 -> all 0x00 with QV pulses. Assert RSTB at edge 5 of a second clear -> INIT_DONE=0 and a full 12-edge clear is repeated.
- Masked write: write D=0xFF M=0xFF to row 3, then D=0x00 M=0x0F -> read row 3 returns 0xF0. With M=0x00 the row is unchanged.
- Latency: READ_LATENCY=2, RE pulsed at edges 1,2,3 on rows 0,1,2 -> QV high after edges 2,3,4 with matching data. Q is held after QV drops.
- Collision: row 5=0xAA, then same-cycle read/write of row 5 with D=0x55 M=0xFF. COLLISION_MODE=0 -> Q=0xAA; COLLISION_MODE=1 -> Q=0x55. A following read returns 0x55 in both modes.
- Out of range: write to AB=13 then read AA=13 -> Q=0x00 with QV=1, and no in-range row changes.
- Busy ignore: issue RE/WE during CLEAR with D=0x77 -> no QV. After INIT_DONE the targeted row reads 0x00.
